// File: rtl/la_iotxdrv_pkg.sv
// Shared iolib definitions for the transmit IO cell: FSM state encodings and
// cfg field offsets.
package la_iotxdrv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_DRIVE = 2'd2,
    ST_HOLD  = 2'd3
  } txstate_t;

  localparam int CFG_DS_LSB   = 0;
  localparam int CFG_DS_W     = 2;
  localparam int CFG_TURN_LSB = 4;
  localparam int CFG_HOLD_LSB = 8;
  localparam int CFG_BYP_BIT  = 12;
  localparam int CNT_W        = 4;

  // The pad is owned by this cell in both the steady drive and turn-off states.
  function automatic logic is_driving(input txstate_t s);
    return (s == ST_DRIVE) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/la_iotxdrv_timer.sv
// 4-bit load/decrement interval counter with a zero flag; decrement saturates
// at zero so a late dec never wraps into a long interval.
module la_iotxdrv_timer
  import la_iotxdrv_pkg::*;
(
  input  logic             clk,
  input  logic             nreset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] ld_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Interval count register; load wins over decrement.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= ld_val;
    end else if (dec && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/la_iotxdrv.sv
// Clocked digital output IO cell: registers core data and drives the pad under
// an output-enable FSM with programmable turn-on and turn-off intervals.
module la_iotxdrv
  import la_iotxdrv_pkg::*;
#(
  parameter PROP  = "DEFAULT",
  parameter SIDE  = "NO",
  parameter int CFGW  = 16,
  parameter int RINGW = 8
) (
  input  logic             clk,
  input  logic             nreset,
  inout  wire              pad,
  inout  wire              vdd,
  inout  wire              vss,
  inout  wire              vddio,
  inout  wire              vssio,
  input  logic             a,
  input  logic             oe,
  output logic             active,
  output logic             zfb,
  inout  wire  [RINGW-1:0] ioring,
  input  logic [CFGW-1:0]  cfg
);

  txstate_t         state_r;
  logic             dreg_r;
  logic             zfb_r;
  logic [CNT_W-1:0] turn_s;
  logic [CNT_W-1:0] hold_s;
  logic             byp_s;
  logic             load_s;
  logic             dec_s;
  logic [CNT_W-1:0] ld_val_s;
  logic [CNT_W-1:0] cnt_s;
  logic             zero_s;
  logic             active_s;
  logic             unused_s;

  assign turn_s   = cfg[CFG_TURN_LSB +: CNT_W];
  assign hold_s   = cfg[CFG_HOLD_LSB +: CNT_W];
  assign byp_s    = cfg[CFG_BYP_BIT];
  assign active_s = is_driving(state_r);

  // Drive strength, supplies and ring belong to the hard macro that replaces
  // this behavioural model.
  assign unused_s = ^{cfg, cfg[CFG_DS_LSB +: CFG_DS_W], vdd, vss, vddio, vssio, ioring,
                      (PROP != ""), (SIDE != "")};

  // Timer control: intervals load as N-1 so N edges elapse before the transition.
  always_comb begin
    load_s   = 1'b0;
    dec_s    = 1'b0;
    ld_val_s = 4'd0;
    case (state_r)
      ST_IDLE: begin
        if (oe && (turn_s != 4'd0)) begin
          load_s   = 1'b1;
          ld_val_s = turn_s - 4'd1;
        end else begin
          load_s   = 1'b0;
        end
      end
      ST_ARM: begin
        if (oe && !zero_s) begin
          dec_s = 1'b1;
        end else begin
          dec_s = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (!oe && (hold_s != 4'd0)) begin
          load_s   = 1'b1;
          ld_val_s = hold_s - 4'd1;
        end else begin
          load_s   = 1'b0;
        end
      end
      ST_HOLD: begin
        if (!oe && !zero_s) begin
          dec_s = 1'b1;
        end else begin
          dec_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
        dec_s  = 1'b0;
      end
    endcase
  end

  la_iotxdrv_timer u_timer (
    .clk    (clk),
    .nreset (nreset),
    .load   (load_s),
    .dec    (dec_s),
    .ld_val (ld_val_s),
    .cnt    (cnt_s),
    .zero   (zero_s)
  );

  // Output-enable FSM; oe loss in ARM and oe return in HOLD beat expiry.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (oe) state_r <= (turn_s == 4'd0) ? ST_DRIVE : ST_ARM;
          else    state_r <= ST_IDLE;
        end
        ST_ARM: begin
          if (!oe)        state_r <= ST_IDLE;
          else if (zero_s) state_r <= ST_DRIVE;
          else            state_r <= ST_ARM;
        end
        ST_DRIVE: begin
          if (!oe) state_r <= (hold_s == 4'd0) ? ST_IDLE : ST_HOLD;
          else     state_r <= ST_DRIVE;
        end
        ST_HOLD: begin
          if (oe)          state_r <= ST_DRIVE;
          else if (zero_s) state_r <= ST_IDLE;
          else             state_r <= ST_HOLD;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Data capture and pad readback, independent of FSM state.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      dreg_r <= 1'b0;
      zfb_r  <= 1'b0;
    end else begin
      dreg_r <= a;
      zfb_r  <= pad;
    end
  end

  assign pad    = active_s ? (byp_s ? a : dreg_r) : 1'bz;
  assign active = active_s;
  assign zfb    = zfb_r;

endmodule

// File: tb/tb_la_iotxdrv.sv
// Directed self-checking bench for la_iotxdrv: reset, turn-on/off intervals,
// abort, re-enable in HOLD and the data path in both bypass modes.
module tb_la_iotxdrv;

  logic        clk = 1'b0;
  logic        nreset;
  logic        a;
  logic        oe;
  logic [15:0] cfg;
  logic        active;
  logic        zfb;
  wire         pad;
  wire         vdd, vss, vddio, vssio;
  wire  [7:0]  ioring;

  int errors = 0;
  int checks = 0;

  assign vdd    = 1'b1;
  assign vss    = 1'b0;
  assign vddio  = 1'b1;
  assign vssio  = 1'b0;
  assign ioring = 8'h00;

  always #5 clk = ~clk;

  la_iotxdrv #(.PROP("DEFAULT"), .SIDE("NO"), .CFGW(16), .RINGW(8)) dut (
    .clk    (clk),
    .nreset (nreset),
    .pad    (pad),
    .vdd    (vdd),
    .vss    (vss),
    .vddio  (vddio),
    .vssio  (vssio),
    .a      (a),
    .oe     (oe),
    .active (active),
    .zfb    (zfb),
    .ioring (ioring),
    .cfg    (cfg)
  );

  function automatic logic [15:0] mkcfg(input logic byp, input logic [3:0] hold,
                                        input logic [3:0] turn);
    return {3'b000, byp, hold, turn, 2'b00, 2'b01};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b0; a = 1'b1; oe = 1'b0; cfg = mkcfg(1'b0, 4'd0, 4'd0);
    #2;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (zfb !== 1'b0) begin errors++; $display("FAIL reset_zfb got=%b exp=0", zfb); end
    tick();
    nreset = 1'b1;
    oe = 1'b1;
    tick();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL rst_drive_active got=%b exp=1", active); end
    checks++; if (pad !== 1'b1) begin errors++; $display("FAIL rst_drive_pad got=%b exp=1", pad); end
    tick();
    checks++; if (zfb !== 1'b1) begin errors++; $display("FAIL rst_drive_zfb got=%b exp=1", zfb); end
    nreset = 1'b0;
    #2;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL midrst_active got=%b exp=0", active); end
    checks++; if (zfb !== 1'b0) begin errors++; $display("FAIL midrst_zfb got=%b exp=0", zfb); end
    checks++; if (dut.dreg_r !== 1'b0) begin errors++; $display("FAIL midrst_dreg got=%b exp=0", dut.dreg_r); end
    tick();
    oe = 1'b0;
    nreset = 1'b1;
    tick();
  endtask

  task automatic test_turn_on();
    cfg = mkcfg(1'b0, 4'd0, 4'd3);
    a = 1'b1;
    oe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL turnon_wait%0d active got=%b exp=0", i, active); end
    end
    tick();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL turnon_active got=%b exp=1", active); end
    checks++; if (pad !== 1'b1) begin errors++; $display("FAIL turnon_pad got=%b exp=1", pad); end
  endtask

  task automatic test_turn_off();
    cfg = mkcfg(1'b0, 4'd2, 4'd3);
    a = 1'b1;
    oe = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      // HOLD was latched at load; a later change must not stretch the interval
      cfg = mkcfg(1'b0, 4'd9, 4'd3);
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL turnoff_hold%0d active got=%b exp=1", i, active); end
      checks++; if (pad !== 1'b1) begin errors++; $display("FAIL turnoff_hold%0d pad got=%b exp=1", i, pad); end
    end
    tick();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL turnoff_release active got=%b exp=0", active); end
  endtask

  task automatic test_abort();
    cfg = mkcfg(1'b0, 4'd0, 4'd5);
    oe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL abort_arm%0d active got=%b exp=0", i, active); end
    end
    oe = 1'b0;
    tick();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL abort_end active got=%b exp=0", active); end
    checks++; if (dut.state_r !== 2'd0) begin errors++; $display("FAIL abort_state got=%0d exp=0", dut.state_r); end
  endtask

  task automatic test_reenable();
    cfg = mkcfg(1'b0, 4'd4, 4'd0);
    a = 1'b0;
    oe = 1'b1;
    tick();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL reen_drive active got=%b exp=1", active); end
    oe = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL reen_hold%0d active got=%b exp=1", i, active); end
    end
    oe = 1'b1;
    tick();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL reen_back active got=%b exp=1", active); end
    checks++; if (dut.state_r !== 2'd2) begin errors++; $display("FAIL reen_state got=%0d exp=2", dut.state_r); end
    tick();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL reen_stay active got=%b exp=1", active); end
  endtask

  task automatic test_datapath();
    logic [5:0] pat;
    logic       prev;
    pat = 6'b101101;
    cfg = mkcfg(1'b0, 4'd0, 4'd0);
    oe = 1'b1;
    a = 1'b0;
    tick();
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = pat[i];
      tick();
      checks++; if (pad !== pat[i]) begin errors++; $display("FAIL dp_reg%0d pad got=%b exp=%b", i, pad, pat[i]); end
      checks++; if (zfb !== prev) begin errors++; $display("FAIL dp_reg%0d zfb got=%b exp=%b", i, zfb, prev); end
      prev = pat[i];
    end
    cfg = mkcfg(1'b1, 4'd0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      a = ~pat[i];
      #1;
      checks++; if (pad !== ~pat[i]) begin errors++; $display("FAIL dp_byp%0d pad got=%b exp=%b", i, pad, ~pat[i]); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_turn_on();
    test_turn_off();
    test_abort();
    test_reenable();
    test_datapath();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
